// File: rtl/lc3b_mem_pkg.sv
// Shared constants, state encoding and lane-enable helper for the LC-3b
// memory responder.
package lc3b_mem_pkg;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte-lane write enables: {high lane, low lane}.
  function automatic logic [1:0] lane_we(input logic size, input logic a0);
    if (size == SIZE_WORD) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// Single-port synchronous RAM built from two 8-bit lanes with per-lane write
// enables and a registered read port that holds between reads.
module lc3b_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem_lo [DEPTH];
  logic [7:0] mem_hi [DEPTH];

  // Lane writes.
  // NOTE: storage arrays carry no reset; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we[0]) mem_lo[addr] <= wdata[7:0];
    if (we[1]) mem_hi[addr] <= wdata[15:8];
  end

  // Registered read; the value is held until the next read enable.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= {mem_hi[addr], mem_lo[addr]};
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b MAR/MDR interface: latches a request,
// waits a fixed latency, commits a word/byte access and pulses r.
module lc3b_mem_responder
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mem_rdata,
  output logic        r,
  output logic        unaligned
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept, commit;

  logic               rw_q, size_q, unal_q;
  logic [ADDR_WIDTH:0] mar_q;
  logic [15:0]        mdr_q;

  logic               arr_re;
  logic [1:0]         arr_we;

  // Address bits above the array depth alias onto the same words.
  logic unused_mar_hi;
  assign unused_mar_hi = ^mar[15:ADDR_WIDTH+1];

  // State and latency counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and pulse outputs.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    r         = 1'b0;
    unaligned = 1'b0;
    case (state)
      IDLE: begin
        if (mio_en) begin
          accept = 1'b1;
          if (data_size == SIZE_WORD && mar[0]) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          // Reset on the commit edge wins, so the array never sees the write.
          commit    = rst_n;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        r         = 1'b1;
        unaligned = unal_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q   <= RW_READ;
      size_q <= SIZE_BYTE;
      unal_q <= 1'b0;
      mar_q  <= '0;
      mdr_q  <= '0;
    end else if (accept) begin
      rw_q   <= r_w;
      size_q <= data_size;
      unal_q <= (data_size == SIZE_WORD) && mar[0];
      mar_q  <= mar[ADDR_WIDTH:0];
      mdr_q  <= mdr_in;
    end
  end

  // Array controls are only active on the commit edge.
  assign arr_re = commit && (rw_q == RW_READ);
  assign arr_we = (commit && rw_q == RW_WRITE) ? lane_we(size_q, mar_q[0]) : 2'b00;

  lc3b_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (mar_q[ADDR_WIDTH:1]),
    .wdata (mdr_q),
    .rdata (mem_rdata)
  );

  a_pulse_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    (r || unaligned) |-> (state == RESP));
  a_r_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    r |=> !r);

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed accesses with literal
// expectations plus a timeline model compared against the outputs every cycle.
module tb_lc3b_mem_responder;
  import lc3b_mem_pkg::*;

  localparam int LAT = 5;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic        data_size = 1'b0;
  logic [15:0] mar = '0;
  logic [15:0] mdr_in = '0;
  logic [15:0] mem_rdata;
  logic        r;
  logic        unaligned;

  int n_checks = 0;
  int n_pass   = 0;

  lc3b_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .data_size (data_size),
    .mar       (mar),
    .mdr_in    (mdr_in),
    .mem_rdata (mem_rdata),
    .r         (r),
    .unaligned (unaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- timeline model ----------------
  // cyc = number of rising edges so far; "cycle n" lies between edge n and n+1.
  int          cyc = 0;
  int          e;
  bit          model_ok = 0;
  int          free_at = 0;      // first edge at which a request may be accepted
  int          resp_at = -1;     // cycle in which r must be high
  bit          resp_unal = 0;
  logic [15:0] rd_model = '0;
  bit          p_valid = 0;
  int          p_edge;
  bit          p_rw, p_size;
  logic [15:0] p_addr, p_data;
  int          kb;
  logic [7:0]  mdl_mem [int];    // keyed by byte address within the array

  always @(posedge clk) begin
    e = cyc + 1;
    if (!rst_n) begin
      p_valid  = 0;
      resp_at  = -1;
      resp_unal = 0;
      rd_model = '0;
      free_at  = e + 1;
      model_ok = 1;
    end else if (model_ok) begin
      if (p_valid && e == p_edge) begin
        kb = int'(p_addr[AW:1]) * 2;
        if (p_rw == RW_WRITE) begin
          if (p_size == SIZE_WORD) begin
            mdl_mem[kb]     = p_data[7:0];
            mdl_mem[kb + 1] = p_data[15:8];
          end else if (!p_addr[0]) mdl_mem[kb] = p_data[7:0];
          else mdl_mem[kb + 1] = p_data[15:8];
        end else begin
          rd_model = {(mdl_mem.exists(kb + 1) ? mdl_mem[kb + 1] : 8'hxx),
                      (mdl_mem.exists(kb)     ? mdl_mem[kb]     : 8'hxx)};
        end
        p_valid = 0;
      end
      if (mio_en && e >= free_at) begin
        if (data_size == SIZE_WORD && mar[0]) begin
          resp_at = e; resp_unal = 1; free_at = e + 2;
        end else begin
          resp_at = e + LAT; resp_unal = 0; free_at = e + LAT + 2;
          p_valid = 1; p_edge = e + LAT;
          p_rw = r_w; p_size = data_size; p_addr = mar; p_data = mdr_in;
        end
      end
    end
    cyc = e;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_r",         16'(r),         16'(resp_at == cyc));
      check("cmp_unaligned", 16'(unaligned), 16'(resp_at == cyc && resp_unal));
      check("cmp_rdata",     mem_rdata,      rd_model);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents a request and waits for r. With idle_first the first edge is the
  // RESP->IDLE edge of the previous access and acceptance is the one after.
  task automatic req(input string name, input bit rw, input bit size,
                     input logic [15:0] addr, input logic [15:0] data, input bit idle_first,
                     output int lat, output int at_cyc, output logic [15:0] rd, output logic unal);
    lat = -1; at_cyc = -1; rd = 'x; unal = 1'bx;
    r_w = rw; data_size = size; mar = addr; mdr_in = data; mio_en = 1'b1;
    if (idle_first) @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (r) begin
        lat = i; at_cyc = cyc; rd = mem_rdata; unal = unaligned;
        break;
      end
      // Inputs wander while busy; only the accepted values may matter.
      mar = 16'($urandom); mdr_in = 16'($urandom);
      r_w = 1'($urandom); data_size = 1'($urandom);
    end
    check({name, "_r_seen"}, 16'(lat >= 0), 16'd1);
  endtask

  task automatic op(input string name, input bit rw, input bit size,
                    input logic [15:0] addr, input logic [15:0] data,
                    input int exp_lat, input bit exp_unal, input bit chk_rd, input logic [15:0] exp_rd);
    int lat, at;
    logic [15:0] rd;
    logic un;
    req(name, rw, size, addr, data, 1'b0, lat, at, rd, un);
    mio_en = 1'b0;
    check({name, "_latency"},   16'(lat), 16'(exp_lat));
    check({name, "_unaligned"}, 16'(un),  16'(exp_unal));
    if (chk_rd) check({name, "_rdata"}, rd, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, at0, at1, at2, r_cnt;
    logic [15:0] rd;
    logic un;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_r", 16'(r), 16'd0);
      check("idle_unaligned", 16'(unaligned), 16'd0);
      check("idle_rdata", mem_rdata, 16'h0000);
    end

    // Word write then read back.
    op("w_beef",  RW_WRITE, SIZE_WORD, 16'h0010, 16'hBEEF, LAT, 1'b0, 1'b0, 16'h0);
    op("r_beef",  RW_READ,  SIZE_WORD, 16'h0010, 16'h0000, LAT, 1'b0, 1'b1, 16'hBEEF);

    // Byte lanes.
    op("wb_lo",   RW_WRITE, SIZE_BYTE, 16'h0010, 16'h1212, LAT, 1'b0, 1'b0, 16'h0);
    op("r_be12",  RW_READ,  SIZE_WORD, 16'h0010, 16'h0000, LAT, 1'b0, 1'b1, 16'hBE12);
    op("wb_hi",   RW_WRITE, SIZE_BYTE, 16'h0011, 16'h3434, LAT, 1'b0, 1'b0, 16'h0);
    op("r_3412",  RW_READ,  SIZE_WORD, 16'h0010, 16'h0000, LAT, 1'b0, 1'b1, 16'h3412);
    op("rb_odd",  RW_READ,  SIZE_BYTE, 16'h0011, 16'h0000, LAT, 1'b0, 1'b1, 16'h3412);

    // Unaligned word accesses: immediate response, no array effect.
    op("w_unal",  RW_WRITE, SIZE_WORD, 16'h0011, 16'hFFFF, 0, 1'b1, 1'b1, 16'h3412);
    op("r_unal",  RW_READ,  SIZE_WORD, 16'h0011, 16'h0000, 0, 1'b1, 1'b1, 16'h3412);
    op("r_after_unal", RW_READ, SIZE_WORD, 16'h0010, 16'h0000, LAT, 1'b0, 1'b1, 16'h3412);

    // Reset two cycles into a write aborts it.
    op("w_5555",  RW_WRITE, SIZE_WORD, 16'h0020, 16'h5555, LAT, 1'b0, 1'b0, 16'h0);
    r_w = RW_WRITE; data_size = SIZE_WORD; mar = 16'h0020; mdr_in = 16'hAAAA; mio_en = 1'b1;
    @(posedge clk);
    @(negedge clk); mio_en = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    r_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r) r_cnt++;
    end
    check("abort_no_r", 16'(r_cnt), 16'd0);
    check("abort_rdata_reset", mem_rdata, 16'h0000);
    op("r_5555",  RW_READ,  SIZE_WORD, 16'h0020, 16'h0000, LAT, 1'b0, 1'b1, 16'h5555);

    // Back-to-back reads with mio_en held high throughout.
    op("w_0", RW_WRITE, SIZE_WORD, 16'h0000, 16'h1111, LAT, 1'b0, 1'b0, 16'h0);
    op("w_2", RW_WRITE, SIZE_WORD, 16'h0002, 16'h2222, LAT, 1'b0, 1'b0, 16'h0);
    op("w_4", RW_WRITE, SIZE_WORD, 16'h0004, 16'h4444, LAT, 1'b0, 1'b0, 16'h0);
    req("b2b0", RW_READ, SIZE_WORD, 16'h0000, 16'h0000, 1'b0, lat, at0, rd, un);
    check("b2b0_rdata", rd, 16'h1111);
    req("b2b1", RW_READ, SIZE_WORD, 16'h0002, 16'h0000, 1'b1, lat, at1, rd, un);
    check("b2b1_rdata", rd, 16'h2222);
    check("b2b1_latency", 16'(lat), 16'(LAT));
    req("b2b2", RW_READ, SIZE_WORD, 16'h0004, 16'h0000, 1'b1, lat, at2, rd, un);
    check("b2b2_rdata", rd, 16'h4444);
    // Pulses start LATENCY+2 cycles apart: LATENCY+1 quiet cycles in between.
    check("b2b_spacing_1", 16'(at1 - at0), 16'(LAT + 2));
    check("b2b_spacing_2", 16'(at2 - at1), 16'(LAT + 2));
    mio_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
